// File: rtl/cache_req_seq.sv
// Initiator-side request sequencer: one reference at a time, search/update on the
// cache-set bus, line fetch on miss. Hit/miss counters are built only when CACHE_SEQ_STATS_EN is defined.
module cache_req_seq #(
  parameter  int INDEX_W  = 4,
  localparam int NUM_SETS = 2**INDEX_W,
  localparam int TAG_W    = 29 - INDEX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ref_valid,
  output logic                ref_ready,
  input  logic [31:0]         ref_addr,
  output logic [TAG_W-1:0]    set_tag,
  output logic [NUM_SETS-1:0] set_enable,
  output logic                set_state,
  output logic                set_mem_write,
  output logic [63:0]         set_write_data,
  input  logic                set_hit,
  output logic                mem_req,
  output logic [31:0]         mem_addr,
  input  logic                mem_ack,
  input  logic [63:0]         mem_rdata,
  output logic                rsp_valid,
  output logic                rsp_hit,
  input  logic                rsp_ready,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    CHECK  = 3'd2,
    FETCH  = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } state_e;

  function automatic logic [NUM_SETS-1:0] onehot(input logic [INDEX_W-1:0] idx);
    logic [NUM_SETS-1:0] v;
    v      = {NUM_SETS{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]    set_tag_q, set_tag_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [63:0]         line_q, line_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic                ref_ready_q, ref_ready_d;
  logic [NUM_SETS-1:0] set_enable_q, set_enable_d;
  logic                set_state_q, set_state_d;
  logic                set_mem_write_q, set_mem_write_d;
  logic                mem_req_q, mem_req_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                count_hit_s, count_miss_s;

  // Next-state logic; bus outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    set_tag_d    = set_tag_q;
    mem_addr_d   = mem_addr_q;
    line_d       = line_q;
    rsp_hit_d    = rsp_hit_q;
    count_hit_s  = 1'b0;
    count_miss_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (ref_valid) begin
          state_d    = SEARCH;
          idx_d      = ref_addr[3+INDEX_W-1:3];
          set_tag_d  = ref_addr[31:3+INDEX_W];
          mem_addr_d = {ref_addr[31:3], 3'b000};
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: state_d = CHECK;
      CHECK: begin
        if (set_hit) begin
          rsp_hit_d = 1'b1;
          state_d   = DONE;
        end else begin
          rsp_hit_d = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          line_d  = mem_rdata;
          state_d = UPDATE;
        end else begin
          state_d = FETCH;
        end
      end
      UPDATE: state_d = DONE;
      DONE: begin
        if (rsp_ready) begin
          count_hit_s  = rsp_hit_q;
          count_miss_s = ~rsp_hit_q;
          state_d      = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    ref_ready_d     = (state_d == IDLE);
    set_state_d     = (state_d == CHECK) || (state_d == UPDATE);
    set_mem_write_d = (state_d == UPDATE);
    mem_req_d       = (state_d == FETCH);
    rsp_valid_d     = (state_d == DONE);
    if ((state_d == SEARCH) || (state_d == UPDATE)) begin
      set_enable_d = onehot(idx_d);
    end else begin
      set_enable_d = {NUM_SETS{1'b0}};
    end
  end

  // Sequencer state and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= {INDEX_W{1'b0}};
      set_tag_q       <= {TAG_W{1'b0}};
      mem_addr_q      <= 32'd0;
      line_q          <= 64'd0;
      rsp_hit_q       <= 1'b0;
      ref_ready_q     <= 1'b1;
      set_enable_q    <= {NUM_SETS{1'b0}};
      set_state_q     <= 1'b0;
      set_mem_write_q <= 1'b0;
      mem_req_q       <= 1'b0;
      rsp_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      set_tag_q       <= set_tag_d;
      mem_addr_q      <= mem_addr_d;
      line_q          <= line_d;
      rsp_hit_q       <= rsp_hit_d;
      ref_ready_q     <= ref_ready_d;
      set_enable_q    <= set_enable_d;
      set_state_q     <= set_state_d;
      set_mem_write_q <= set_mem_write_d;
      mem_req_q       <= mem_req_d;
      rsp_valid_q     <= rsp_valid_d;
    end
  end

  assign ref_ready      = ref_ready_q;
  assign set_tag        = set_tag_q;
  assign set_enable     = set_enable_q;
  assign set_state      = set_state_q;
  assign set_mem_write  = set_mem_write_q;
  assign set_write_data = line_q;
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_hit        = rsp_hit_q;

`ifdef CACHE_SEQ_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Saturating statistics, one increment per completed response.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (count_hit_s && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end else begin
      hit_count_d = hit_count_q;
    end
    if (count_miss_s && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end else begin
      miss_count_d = miss_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_count_s;
  assign unused_count_s = count_hit_s ^ count_miss_s;
  assign hit_count      = 32'd0;
  assign miss_count     = 32'd0;
`endif

endmodule

// File: tb/tb_cache_req_seq.sv
// Directed bench for cache_req_seq: a queue holds the expected hit/miss of each
// reference and is popped when the response appears.
module tb_cache_req_seq;

  logic        clk;
  logic        rst_n;
  logic        ref_valid;
  logic        ref_ready;
  logic [31:0] ref_addr;
  logic [24:0] set_tag;
  logic [15:0] set_enable;
  logic        set_state;
  logic        set_mem_write;
  logic [63:0] set_write_data;
  logic        set_hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_hit;
  logic        rsp_ready;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

`ifdef CACHE_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int        n_checks = 0;
  int        n_fail   = 0;
  int        cyc      = 0;
  bit        sb[$];
  bit        exp_hit_q;
  logic [31:0] model_hits  = 32'd0;
  logic [31:0] model_miss  = 32'd0;

  cache_req_seq #(.INDEX_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ref_valid      (ref_valid),
    .ref_ready      (ref_ready),
    .ref_addr       (ref_addr),
    .set_tag        (set_tag),
    .set_enable     (set_enable),
    .set_state      (set_state),
    .set_mem_write  (set_mem_write),
    .set_write_data (set_write_data),
    .set_hit        (set_hit),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .rsp_valid      (rsp_valid),
    .rsp_hit        (rsp_hit),
    .rsp_ready      (rsp_ready),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_hits"}, hit_count,  STATS ? model_hits : 32'd0);
    chk({tag, "_miss"}, miss_count, STATS ? model_miss : 32'd0);
  endtask

  // One complete reference; called and returns at a negedge.
  task automatic run_ref(input logic [31:0] addr, input bit hit, input int k,
                         input int bp, input logic [63:0] line);
    logic [24:0] etag;
    logic [15:0] een;
    etag = addr[31:7];
    een  = 16'd1 << addr[6:3];
    chk("idle_ready", ref_ready, 1'b1);
    ref_valid = 1'b1;
    ref_addr  = addr;
    sb.push_back(hit);
    cyc = 0;
    nxt();
    ref_valid = 1'b0;
    ref_addr  = $urandom;
    chk("search_state", set_state, 1'b0);
    chk("search_enable", set_enable, een);
    chk("search_tag", set_tag, etag);
    chk("search_ready", ref_ready, 1'b0);
    nxt();
    chk("check_state", set_state, 1'b1);
    chk("check_enable", set_enable, 16'd0);
    set_hit = hit;
    nxt();
    set_hit = 1'b0;
    if (!hit) begin
      for (int j = 1; j <= k; j++) begin
        chk("fetch_req", mem_req, 1'b1);
        chk("fetch_addr", mem_addr, {addr[31:3], 3'b000});
        mem_ack   = (j == k);
        mem_rdata = (j == k) ? line : {$urandom, $urandom};
        nxt();
      end
      mem_ack   = 1'b0;
      mem_rdata = {$urandom, $urandom};
      chk("upd_write", set_mem_write, 1'b1);
      chk("upd_enable", set_enable, een);
      chk("upd_data", set_write_data, line);
      chk("upd_state", set_state, 1'b1);
      chk("upd_req_low", mem_req, 1'b0);
      nxt();
    end else begin
      chk("hit_no_req", mem_req, 1'b0);
    end
    for (int w = 0; w < 20 && rsp_valid !== 1'b1; w++) nxt();
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_cycle", cyc, hit ? 3 : 4 + k);
    for (int b = 0; b < bp; b++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_hit", rsp_hit, hit);
      chk("bp_ready", ref_ready, 1'b0);
      chk_counts("bp");
      nxt();
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
    end else begin
      exp_hit_q = sb.pop_front();
      chk("rsp_hit", rsp_hit, exp_hit_q);
    end
    chk_counts("pre_hs");
    rsp_ready = 1'b1;
    nxt();
    rsp_ready = 1'b0;
    if (hit) model_hits = model_hits + 32'd1;
    else     model_miss = model_miss + 32'd1;
    chk("post_ready", ref_ready, 1'b1);
    chk("post_valid", rsp_valid, 1'b0);
    chk_counts("post");
  endtask

  initial begin
    rst_n     = 1'b0;
    ref_valid = 1'b0;
    ref_addr  = 32'd0;
    set_hit   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 64'd0;
    rsp_ready = 1'b0;

    // Reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ref_valid = 1'($urandom);
      ref_addr  = $urandom;
      set_hit   = 1'($urandom);
      mem_ack   = 1'($urandom);
      mem_rdata = {$urandom, $urandom};
      rsp_ready = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_ready", ref_ready, 1'b1);
    chk("rst_enable", set_enable, 16'd0);
    chk("rst_state", set_state, 1'b0);
    chk("rst_write", set_mem_write, 1'b0);
    chk("rst_tag", set_tag, 25'd0);
    chk("rst_wdata", set_write_data, 64'd0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_hit", rsp_hit, 1'b0);
    chk("rst_hitcnt", hit_count, 32'd0);
    chk("rst_misscnt", miss_count, 32'd0);
    ref_valid = 1'b0;
    set_hit   = 1'b0;
    mem_ack   = 1'b0;
    rsp_ready = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    run_ref(32'h0000_123C, 1'b0, 1, 0, 64'hDEAD_BEEF_0123_4567);
    run_ref(32'h0000_123C, 1'b1, 0, 0, 64'd0);
    run_ref(32'h0ABC_DEF8, 1'b0, 5, 0, 64'h1122_3344_5566_7788);
    run_ref(32'h8000_0040, 1'b1, 0, 4, 64'd0);
    run_ref(32'hFFFF_FFF8, 1'b0, 2, 4, 64'hA5A5_5A5A_0F0F_F0F0);

    // Reset in the middle of a fetch
    ref_valid = 1'b1;
    ref_addr  = 32'h0000_5550;
    sb.push_back(1'b0);
    @(negedge clk);
    ref_valid = 1'b0;
    @(negedge clk);
    set_hit = 1'b0;
    @(negedge clk);
    chk("midrst_req_before", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", mem_req, 1'b0);
    chk("midrst_ready", ref_ready, 1'b1);
    chk("midrst_tag", set_tag, 25'd0);
    chk("midrst_valid", rsp_valid, 1'b0);
    chk("midrst_hitcnt", hit_count, 32'd0);
    chk("midrst_misscnt", miss_count, 32'd0);
    sb.delete();
    model_hits = 32'd0;
    model_miss = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_ref(32'h0000_123C, 1'b0, 1, 0, 64'h0BAD_F00D_CAFE_0001);
    run_ref(32'h0000_0008, 1'b1, 0, 0, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
